// File: rtl/sr_link_pkg.sv
`default_nettype none
// ============================================================================
// sr_link_pkg : shared FSM encoding and PRBS7 constants for sr_link_checker
// Rev 1.0
// ============================================================================
package sr_link_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FLUSH = 3'd1,
      ST_PROBE = 3'd2,
      ST_SEED  = 3'd3,
      ST_CHECK = 3'd4,
      ST_DONE  = 3'd5
   } state_t;

   localparam logic [6:0] PRBS7_TAPS  = 7'h60;
   localparam logic [6:0] PRBS7_SEED  = 7'h7F;
   localparam int         SYNC_STAGES = 2;

   // Next PRBS7 bit (x^7 + x^6 + 1) for a state whose bit 0 is the newest bit.
   function automatic logic prbs7_fb(input logic [6:0] s);
      return ^(s & PRBS7_TAPS);
   endfunction

endpackage
`default_nettype wire

// File: rtl/sr_link_checker_if.sv
`default_nettype none
// ============================================================================
// sr_link_checker_if : control/result bus plus chain serial pins
// Rev 1.0
// ============================================================================
interface sr_link_checker_if #(
   parameter int LAT_W = 10,
   parameter int ERR_W = 16
);
   logic             start;
   logic             tx_bit;
   logic             rx_bit;
   logic             busy;
   logic             done;
   logic             lat_valid;
   logic [LAT_W-1:0] lat;
   logic             timeout;
   logic [ERR_W-1:0] err_cnt;

   modport master (
      output start, rx_bit,
      input  tx_bit, busy, done, lat_valid, lat, timeout, err_cnt
   );

   modport slave (
      input  start, rx_bit,
      output tx_bit, busy, done, lat_valid, lat, timeout, err_cnt
   );
endinterface
`default_nettype wire

// File: rtl/prbs7_lfsr.sv
`default_nettype none
// ============================================================================
// prbs7_lfsr : PRBS7 generator; out is the bit the next advance shifts in
// Rev 1.0
// ============================================================================
module prbs7_lfsr
   import sr_link_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       load,
   input  logic [6:0] load_val,
   output logic       out
);

   logic [6:0] r_state;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= PRBS7_SEED;
      end else if (load) begin
         r_state <= load_val;
      end else if (en) begin
         r_state <= {r_state[5:0], prbs7_fb(r_state)};
      end
   end

   assign out = prbs7_fb(r_state);

endmodule
`default_nettype wire

// File: rtl/sr_link_checker.sv
`default_nettype none
// ============================================================================
// sr_link_checker : measures shift-chain loop delay, then PRBS7 bit-error count
// Rev 1.0
// ============================================================================
module sr_link_checker
   import sr_link_pkg::*;
#(
   parameter int MAX_LAT      = 1023,
   parameter int LAT_W        = 10,
   parameter int BIT_CYC_LOG2 = 1,
   parameter int N_CHECK      = 1024,
   parameter int ERR_W        = 16
)(
   input logic clk,
   input logic rst_n,
   sr_link_checker_if.slave bus
);

   localparam int CNT_W = LAT_W + 1;
   localparam int PH_W  = (BIT_CYC_LOG2 > 0) ? BIT_CYC_LOG2 : 1;
   localparam int CHK_W = $clog2(N_CHECK + 1);

   localparam logic [PH_W-1:0]  c_ph_last    = PH_W'((1 << BIT_CYC_LOG2) - 1);
   localparam logic [CNT_W-1:0] c_flush_last = CNT_W'(MAX_LAT + 1);
   localparam logic [CNT_W-1:0] c_probe_last = CNT_W'(MAX_LAT + 2);
   localparam logic [CNT_W-1:0] c_sync_dly   = CNT_W'(SYNC_STAGES);
   localparam logic [CHK_W-1:0] c_chk_last   = CHK_W'(N_CHECK - 1);
   localparam logic [ERR_W-1:0] c_err_max    = '1;

   state_t                 r_state;
   logic [CNT_W-1:0]       r_cnt;
   logic [PH_W-1:0]        r_ph;
   logic [PH_W-1:0]        r_rph;
   logic [SYNC_STAGES-1:0] r_sync;
   logic [5:0]             r_seed_sh;
   logic [2:0]             r_seed_n;
   logic [CHK_W-1:0]       r_chk_n;
   logic                   r_tx;
   logic                   r_busy;
   logic                   r_done;
   logic                   r_lat_valid;
   logic [LAT_W-1:0]       r_lat;
   logic                   r_timeout;
   logic [ERR_W-1:0]       r_err;

   logic w_rx_s, w_armed, w_strobe, w_in_stream;
   logic w_tx_adv, w_tx_load, w_tx_prbs, w_pred;
   logic w_pred_load, w_pred_en;

   assign w_rx_s      = r_sync[SYNC_STAGES-1];
   assign w_in_stream = (r_state == ST_SEED) || (r_state == ST_CHECK);
   // r_cnt stops at lat+2 in SEED/CHECK; from then on r_rph tracks the received bit phase.
   assign w_armed     = (r_cnt == ({1'b0, r_lat} + c_sync_dly));
   assign w_strobe    = w_in_stream && w_armed && (r_rph == c_ph_last);
   assign w_tx_adv    = ((r_state == ST_PROBE) && w_rx_s) || (w_in_stream && (r_ph == c_ph_last));
   assign w_tx_load   = (r_state == ST_IDLE) && bus.start;
   assign w_pred_load = (r_state == ST_SEED) && w_strobe && (r_seed_n == 3'd6);
   assign w_pred_en   = (r_state == ST_CHECK) && w_strobe;

   prbs7_lfsr u_tx_gen (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (w_tx_adv),
      .load     (w_tx_load),
      .load_val (PRBS7_SEED),
      .out      (w_tx_prbs)
   );

   prbs7_lfsr u_rx_pred (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (w_pred_en),
      .load     (w_pred_load),
      .load_val ({r_seed_sh, w_rx_s}),
      .out      (w_pred)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], bus.rx_bit};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_ph        <= '0;
         r_rph       <= '0;
         r_seed_sh   <= '0;
         r_seed_n    <= '0;
         r_chk_n     <= '0;
         r_tx        <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_lat_valid <= 1'b0;
         r_lat       <= '0;
         r_timeout   <= 1'b0;
         r_err       <= '0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            ST_IDLE: begin
               r_tx <= 1'b0;
               if (bus.start) begin
                  r_state     <= ST_FLUSH;
                  r_busy      <= 1'b1;
                  r_cnt       <= '0;
                  r_lat_valid <= 1'b0;
                  r_lat       <= '0;
                  r_timeout   <= 1'b0;
                  r_err       <= '0;
               end
            end
            ST_FLUSH: begin
               if (r_cnt != c_flush_last) begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end else if (w_rx_s) begin
                  r_timeout <= 1'b1;
                  r_state   <= ST_DONE;
                  r_done    <= 1'b1;
                  r_busy    <= 1'b0;
               end else begin
                  r_state <= ST_PROBE;
                  r_tx    <= 1'b1;
                  r_cnt   <= '0;
               end
            end
            ST_PROBE: begin
               // A rise seen on the last allowed count still wins over the timeout.
               if (w_rx_s) begin
                  r_lat       <= LAT_W'(r_cnt - c_sync_dly);
                  r_lat_valid <= 1'b1;
                  r_state     <= ST_SEED;
                  r_tx        <= w_tx_prbs;
                  r_cnt       <= '0;
                  r_ph        <= '0;
                  r_rph       <= '0;
                  r_seed_n    <= '0;
               end else if (r_cnt == c_probe_last) begin
                  r_timeout <= 1'b1;
                  r_tx      <= 1'b0;
                  r_state   <= ST_DONE;
                  r_done    <= 1'b1;
                  r_busy    <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            ST_SEED, ST_CHECK: begin
               r_ph <= (r_ph == c_ph_last) ? '0 : r_ph + PH_W'(1);
               if (r_ph == c_ph_last) begin
                  r_tx <= w_tx_prbs;
               end
               if (!w_armed) begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end else begin
                  r_rph <= (r_rph == c_ph_last) ? '0 : r_rph + PH_W'(1);
               end
               if (w_strobe && (r_state == ST_SEED)) begin
                  r_seed_sh <= {r_seed_sh[4:0], w_rx_s};
                  r_seed_n  <= r_seed_n + 3'd1;
                  if (r_seed_n == 3'd6) begin
                     r_state <= ST_CHECK;
                     r_chk_n <= '0;
                  end
               end else if (w_strobe) begin
                  if ((w_rx_s != w_pred) && (r_err != c_err_max)) begin
                     r_err <= r_err + ERR_W'(1);
                  end
                  if (r_chk_n == c_chk_last) begin
                     r_state <= ST_DONE;
                     r_done  <= 1'b1;
                     r_busy  <= 1'b0;
                     r_tx    <= 1'b0;
                  end else begin
                     r_chk_n <= r_chk_n + CHK_W'(1);
                  end
               end
            end
            ST_DONE: begin
               r_tx    <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.tx_bit    = r_tx;
   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.lat_valid = r_lat_valid;
   assign bus.lat       = r_lat;
   assign bus.timeout   = r_timeout;
   assign bus.err_cnt   = r_err;

endmodule
`default_nettype wire
